// File: rtl/uart_pkg.sv
// uart_pkg: tx state encoding, parity mode constants and parity helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    function automatic logic parity_bit(input logic [8:0] d, input int mode);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, no bypass; push ignored when full, pop ignored when empty
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    always_comb begin
        do_push = push && !full;
        do_pop = pop && !empty;
        full = count == CW'(DEPTH);
        empty = count == '0;
        rdata = mem[rd_ptr];
    end
    always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter; the parity bit exists only when UART_TX_PARITY_EN is defined
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_W + 1);
    if (DATA_W < 5 || DATA_W > 9 || (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY < 0 || PARITY > 2) begin : g_bad_params
        $error("uart_tx_param: illegal parameter value");
    end
    tx_state_t state;
    logic [DATA_W-1:0] shreg, head;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] count;
    logic stop_cnt, full, empty, pop, last_stop;
`ifdef UART_TX_PARITY_EN
    logic par_bit;
`endif
    uart_tx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) fifo (
        .clk(clk), .rst(rst), .push(valid), .pop(pop), .wdata(data),
        .rdata(head), .full(full), .empty(empty), .count(count)
    );
    always_comb begin
        ready = !full;
        busy = state != IDLE || count != '0;
        last_stop = state == STOP && stop_cnt == 1'(STOP_BITS - 1);
        pop = baud_tick && !empty && (state == IDLE || last_stop);
    end
    // every transition, including back-to-back frame chaining, happens on a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tx <= 1'b1;
            shreg <= '0;
            bit_cnt <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (baud_tick) begin
            case (state)
                IDLE, STOP: begin
                    if (pop) begin
                        state <= START;
                        tx <= 1'b0;
                        shreg <= head;
`ifdef UART_TX_PARITY_EN
                        par_bit <= parity_bit(9'(head), PARITY);
`endif
                    end else if (state == STOP && !last_stop) begin
                        stop_cnt <= 1'b1;
                    end else begin
                        state <= IDLE;
                        tx <= 1'b1;
                    end
                end
                START: begin
                    state <= DATA;
                    tx <= shreg[0];
                    shreg <= shreg >> 1;
                    bit_cnt <= BW'(1);
                end
                DATA: begin
                    if (bit_cnt == BW'(DATA_W)) begin
`ifdef UART_TX_PARITY_EN
                        if (PARITY != PAR_NONE) begin
                            state <= PAR;
                            tx <= par_bit;
                        end else
`endif
                        begin
                            state <= STOP;
                            tx <= 1'b1;
                            stop_cnt <= 1'b0;
                        end
                    end else begin
                        tx <= shreg[0];
                        shreg <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PAR: begin
                    state <= STOP;
                    tx <= 1'b1;
                    stop_cnt <= 1'b0;
                end
`endif
                default: begin
                    state <= IDLE;
                    tx <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench over four parameter sets; line bits predicted from accepted words
`timescale 1ns/1ps
module tb_uart_tx_param;
    localparam int NC = 4;
    localparam int CFG_DW[NC]    = '{8, 8, 7, 8};
    localparam int CFG_SB[NC]    = '{1, 1, 2, 1};
    localparam int CFG_DEPTH[NC] = '{4, 2, 4, 4};
    localparam int CFG_PAR[NC]   = '{2, 1, 0, 0};
`ifdef UART_TX_PARITY_EN
    localparam int CFG_SEQ[NC] = '{'b00010110101, 'b00010110111, 'b0101010111, 'b0001011011};
    localparam int CFG_LEN[NC] = '{11, 11, 10, 10};
`else
    localparam int CFG_SEQ[NC] = '{'b0001011011, 'b0001011011, 'b0101010111, 'b0001011011};
    localparam int CFG_LEN[NC] = '{10, 10, 10, 10};
`endif
    logic clk = 1'b0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int n_done = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int g, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %0d, expected %0d (cycle %0d)", g, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NC; g++) begin : c
        localparam int DW = CFG_DW[g];
        localparam int SB = CFG_SB[g];
        localparam int DEPTH = CFG_DEPTH[g];
        localparam int PARM = CFG_PAR[g];
`ifdef UART_TX_PARITY_EN
        localparam int P = (PARM != 0) ? 1 : 0;
`else
        localparam int P = 0;
`endif
        logic rst = 1'b1;
        logic baud_tick = 1'b0;
        logic valid = 1'b0;
        logic [DW-1:0] data = '0;
        logic ready, tx, busy;
        int per = 4;
        int tcnt = 0;
        int last_tick = -1;
        logic [DW-1:0] pend_w[$];
        int pend_acc[$];
        int bits[$];
        int sent = 0;
        logic from_frame = 1'b0;
        logic cap_en = 1'b0;
        int cap_val = 0;
        int cap_n = 0;

        if (g == NC - 1) begin : d
            uart_tx_param dut (
                .clk(clk), .rst(rst), .baud_tick(baud_tick), .data(data),
                .valid(valid), .ready(ready), .tx(tx), .busy(busy)
            );
        end else begin : p
            uart_tx_param #(.DATA_W(DW), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH), .PARITY(PARM)) dut (
                .clk(clk), .rst(rst), .baud_tick(baud_tick), .data(data),
                .valid(valid), .ready(ready), .tx(tx), .busy(busy)
            );
        end

        // line bits of one frame: start, data LSB first, optional parity, stop bits
        function automatic void load(input logic [DW-1:0] w);
            int ones = $countones(w);
            bits.push_back(0);
            for (int i = 0; i < DW; i++) bits.push_back(int'(w[i]));
            if (P != 0) bits.push_back(PARM == 1 ? 1 - ones % 2 : ones % 2);
            for (int i = 0; i < SB; i++) bits.push_back(1);
        endfunction

        initial forever begin
            @(negedge clk);
            if (tcnt >= per - 1) begin
                baud_tick = 1'b1;
                tcnt = 0;
            end else begin
                baud_tick = 1'b0;
                tcnt++;
            end
        end

        initial begin
            int e;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    pend_w.delete();
                    pend_acc.delete();
                    bits.delete();
                    from_frame = 1'b0;
                    sent = 0;
                    check("rst_tx", g, tx, 1);
                    check("rst_busy", g, busy, 0);
                end else if (baud_tick) begin
                    last_tick = cyc;
                    if (bits.size() == 0) begin
                        sent = 0;
                        if (pend_w.size() != 0 && pend_acc[0] < cyc) begin
                            load(pend_w.pop_front());
                            void'(pend_acc.pop_front());
                        end
                    end
                    from_frame = bits.size() != 0;
                    e = from_frame ? bits.pop_front() : 1;
                    if (from_frame) sent++;
                    check("tx", g, tx, e);
                    check("busy", g, busy, int'(from_frame || pend_w.size() != 0));
                    if (cap_en && from_frame && cap_n < CFG_LEN[g]) begin
                        cap_val = cap_val * 2 + int'(tx);
                        cap_n++;
                    end
                end
            end
        end

        task automatic send(input logic [DW-1:0] w);
            valid = 1'b1;
            data = w;
            for (int i = 0; i < 20000; i++) begin
                check("ready", g, ready, int'(pend_w.size() < DEPTH));
                if (pend_w.size() < DEPTH) begin
                    pend_w.push_back(w);
                    pend_acc.push_back(cyc + 1);
                    @(negedge clk);
                    valid = 1'b0;
                    data = DW'($urandom);
                    return;
                end
                @(negedge clk);
            end
            valid = 1'b0;
            check("push_timeout", g, 1, 0);
        endtask

        task automatic wait_idle();
            int i = 0;
            while ((busy || bits.size() != 0 || pend_w.size() != 0) && i < 20000) begin
                @(negedge clk);
                i++;
            end
            check("idle_timeout", g, busy, 0);
        endtask

        initial begin
            bit reached;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("post_rst_ready", g, ready, 1);
            check("post_rst_busy", g, busy, 0);
            check("post_rst_tx", g, tx, 1);
            per = 130;
            cap_en = 1'b1;
            send(DW == 7 ? DW'(8'h55) : DW'(8'hB4));
            wait_idle();
            cap_en = 1'b0;
            check("seq_bits", g, cap_val, CFG_SEQ[g]);
            check("seq_len", g, cap_n, CFG_LEN[g]);
            // burst right after a tick so the buffer fills before the first pop
            per = 8;
            @(negedge clk);
            for (int i = 0; i < 100 && cyc != last_tick; i++) @(negedge clk);
            for (int k = 0; k < DEPTH + 1; k++) send(DW'($urandom));
            wait_idle();
            per = 4;
            for (int k = 0; k < 3; k++) send(DW'($urandom));
            reached = 1'b0;
            for (int i = 0; i < 2000 && !reached; i++) begin
                reached = sent == 5 && pend_w.size() == 2;
                if (!reached) @(negedge clk);
            end
            if (!reached) check("abort_point_timeout", g, 1, 0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_ready", g, ready, 1);
            check("abort_busy", g, busy, 0);
            check("abort_tx", g, tx, 1);
            repeat (40) @(negedge clk);
            for (int k = 0; k < 30; k++) begin
                per = $urandom_range(1, 4);
                repeat ($urandom_range(0, 20)) @(negedge clk);
                send(DW'($urandom));
            end
            wait_idle();
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 90000 && n_done < NC; i++) @(posedge clk);
        if (n_done < NC) check("global_timeout", -1, n_done, NC);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-003 Parameter FIFO_DEPTH, default 4: transmit buffer words; power of two, at least 2.
REQ-004 Parameter PARITY, default 0: 0 none, 1 odd, 2 even; honoured only per REQ-025.
REQ-005 Port clk, input, 1: single clock; all logic rising-edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port baud_tick, input, 1: one-clk strobe per bit period; each high cycle counts as one tick.
REQ-008 Port data, input, DATA_W: word to transmit.
REQ-009 Port valid, input, 1: data is offered this cycle.
REQ-010 Port ready, output, 1: buffer can accept; transfer occurs when valid && ready.
REQ-011 Port tx, output, 1: serial line, registered, idle high.
REQ-012 Port busy, output, 1: high while a frame is in progress or the buffer is non-empty.

Function
REQ-013 Frame format: start (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-014 The FSM SHALL have states IDLE, START, DATA, PAR, STOP, and it SHALL advance only on cycles with baud_tick high.
- IDLE: on tick with buffer non-empty -> pop head into shift register, tx=0, go to START.
- START: on tick -> DATA, tx = bit0.
- DATA: on tick -> shift; after the last bit, go to PAR (if enabled) or STOP.
- PAR: on tick -> STOP.
- STOP: counts STOP_BITS ticks.
REQ-015 At the final STOP tick, the block SHALL pop and go directly to START (tx=0) if the buffer is non-empty, with no idle bit; otherwise it SHALL go to IDLE.
REQ-016 tx SHALL change on the clk edge following the sampled tick (one-cycle latency); a frame occupies exactly 1+DATA_W+P+STOP_BITS ticks, where P is 0 or 1.
REQ-017 ready = !full, combinational from the registered count; a push with ready low SHALL be ignored.
REQ-018 Simultaneous push and pop SHALL both take effect, with the count unchanged.
REQ-019 Push into an empty buffer SHALL give no bypass: the word is poppable from the next cycle.
REQ-020 Pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-021 A data change while a frame is in flight SHALL not affect that frame, which is taken from the shift register only.
REQ-022 busy = (state != IDLE) || (count != 0).

Reset
REQ-023 rst SHALL force state IDLE, tx=1, busy=0, empty buffer (pointers and count 0), and ready=1 from the first cycle after release.
REQ-024 rst mid-frame SHALL abort the frame immediately; tx SHALL be 1 on the next edge and buffered words SHALL be discarded.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, PARITY SHALL select none/odd/even and the PAR state SHALL be generated.
- Even parity: bit = XOR of data bits.
- Odd parity: bit = its inverse.
REQ-026 With UART_TX_PARITY_EN undefined, the PAR state and parity logic SHALL be absent and PARITY SHALL be ignored (treated as 0).

Structure
REQ-027 Shared package uart_pkg SHALL hold the tx state encoding (IDLE, START, DATA, PAR, STOP) and the parity-mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2).
REQ-028 The buffer SHALL be sub-module uart_tx_fifo with parameters WIDTH and DEPTH, synchronous, with push/pop/full/empty/count signals; the FSM, shift register and bit/stop counters stay in uart_tx_param.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Defaults; push 0xB4 once; tick every 130 clk -> tx bit sequence 0,0,0,1,0,1,1,0,1,1; busy falls after the 10th tick.
- UART_TX_PARITY_EN with PARITY=2, then PARITY=1, 0xB4 -> parity bit 0 (even) and 1 (odd), each frame 11 ticks.
- FIFO_DEPTH=4; push 5 words back-to-back -> ready low after the 4th push (or after the 5th if the first pop occurred); all frames contiguous, no idle tick between stop and start.
- STOP_BITS=2, DATA_W=7, push 0x55 -> 0,1,0,1,0,1,0,1,1,1 (10 ticks).
- rst asserted during DATA bit 3 with 2 words buffered -> tx=1 the next cycle, busy=0, ready=1, no further frames.
- Full buffer with simultaneous pop and valid push -> push rejected (ready was 0), count drops by 1, and the next push is accepted.
